// File: rtl/cpu_pkg.sv
// Shared execute-stage types and constants for the iterative divider.
// Holds the divider state encoding and the two's-complement helpers it uses.
package cpu_pkg;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;

   localparam int          DIV_ITER   = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // Magnitude of v when interpreted as signed; passes v through for unsigned ops.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_sgn);
      return (is_sgn && v[31]) ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the decode/execute register, the divider and writeback.
// The pipeline side is the master; the divider is the slave.
interface div_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor, flush,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor, flush,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/div_iter_adder.sv
// The execute-stage ripple adder, reused by the divider in subtract mode.
// Subtraction is a_i + ~b + 1, so cout_o=1 means no borrow.
module div_iter_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed and unsigned, one quotient bit per cycle.
// Only WIDTH=32 / ITER=32 is supported because the shared adder is fixed at 32 bits.
module div_iter
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = DIV_ITER
) (
   input  logic        clk,
   input  logic        rst_n,
   div_iter_if.slave   dif
);

   localparam int               CNT_W = $clog2(ITER) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

   // Control state and registered outputs
   div_state_t       state_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_zero_q;
   logic [CNT_W-1:0] cnt_q;

   // Working datapath (no reset needed: always loaded before use)
   logic [WIDTH-1:0] q_q,     q_d;
   logic [WIDTH-1:0] r_q,     r_d;
   logic [WIDTH-1:0] dvsr_q,  dvsr_d;
   logic [WIDTH-1:0] dvnd_q,  dvnd_d;
   logic             sgn_q,   sgn_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dz_q,    dz_d;

   logic [WIDTH-1:0] s_w;
   logic [WIDTH-1:0] t_w;
   logic             cout_w;
   logic             acc_w;

   assign s_w   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   // The bit shifted out of R makes S >= 2^32 > divisor, so the trial always fits.
   assign acc_w = r_q[WIDTH-1] | cout_w;

   div_iter_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a_i    (s_w),
      .b_i    (~dvsr_q),
      .cin_i  (1'b1),
      .sum_o  (t_w),
      .cout_o (cout_w)
   );

   always_comb begin
      q_d     = q_q;
      r_d     = r_q;
      dvsr_d  = dvsr_q;
      dvnd_d  = dvnd_q;
      sgn_d   = sgn_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (dif.start) begin
               dvnd_d = dif.dividend;
               dvsr_d = dif.divisor;
               sgn_d  = dif.is_signed;
            end
         end
         PREP: begin
            dz_d = (dvsr_q == '0);
            if (dvsr_q == '0) begin
               q_d     = DIV_ZERO_Q;
               r_d     = dvnd_q;
               q_neg_d = 1'b0;
               r_neg_d = 1'b0;
            end else begin
               q_d     = abs32(dvnd_q, sgn_q);
               r_d     = '0;
               dvsr_d  = abs32(dvsr_q, sgn_q);
               q_neg_d = sgn_q & (dvnd_q[WIDTH-1] ^ dvsr_q[WIDTH-1]);
               r_neg_d = sgn_q & dvnd_q[WIDTH-1];
            end
         end
         CALC: begin
            r_d = acc_w ? t_w : s_w;
            q_d = {q_q[WIDTH-2:0], acc_w};
         end
         FIX: begin
            q_d = q_neg_q ? neg32(q_q) : q_q;
            r_d = r_neg_q ? neg32(r_q) : r_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
   end

   // Results are committed only on leaving DONE so a flush anywhere leaves them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         done_q <= 1'b0;
         if (dif.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (dif.start) begin
                     state_q <= PREP;
                     busy_q  <= 1'b1;
                  end
               end
               PREP: begin
                  cnt_q <= '0;
                  if (dvsr_q == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= CALC;
                  end
               end
               CALC: begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST) begin
                     state_q <= FIX;
                  end
               end
               FIX: begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
               end
               DONE: begin
                  done_q      <= 1'b1;
                  quotient_q  <= q_q;
                  remainder_q <= r_q;
                  div_zero_q  <= dz_q;
                  state_q     <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dif.busy      = busy_q;
   assign dif.done      = done_q;
   assign dif.quotient  = quotient_q;
   assign dif.remainder = remainder_q;
   assign dif.div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: hand-computed quotient/remainder, latency, flush and reset cases.
module tb_div_iter;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   div_iter_if #(.WIDTH(32)) dif ();

   div_iter #(
      .WIDTH (32),
      .ITER  (32)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dif   (dif)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done; lat counts edges after the start edge.
   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      @(negedge clk);
      dif.start     = 1'b1;
      dif.is_signed = sg;
      dif.dividend  = a;
      dif.divisor   = b;
      @(negedge clk);
      dif.start = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!dif.done && lat < 100) begin
         if (dif.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   int lat, bcnt, nd;

   initial begin
      rst_n         = 1'b0;
      dif.start     = 1'b0;
      dif.is_signed = 1'b0;
      dif.dividend  = '0;
      dif.divisor   = '0;
      dif.flush     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(dif.busy), 32'd0);
      chk("rst_done", 32'(dif.done), 32'd0);
      chk("rst_quot", dif.quotient, 32'd0);
      chk("rst_rem",  dif.remainder, 32'd0);
      chk("rst_dz",   32'(dif.div_zero), 32'd0);
      rst_n = 1'b1;

      do_div(1'b0, 32'd100, 32'd7, lat, bcnt);
      chk("u100_7_lat",  lat, 32'd35);
      chk("u100_7_busy", bcnt, 32'd34);
      chk("u100_7_q",    dif.quotient, 32'd14);
      chk("u100_7_r",    dif.remainder, 32'd2);
      chk("u100_7_dz",   32'(dif.div_zero), 32'd0);
      @(negedge clk);
      chk("done_pulse",  32'(dif.done), 32'd0);
      chk("held_q",      dif.quotient, 32'd14);

      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bcnt);
      chk("sm100_7_q", dif.quotient, 32'hFFFF_FFF2);
      chk("sm100_7_r", dif.remainder, 32'hFFFF_FFFE);

      do_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, bcnt);
      chk("s100_m7_q", dif.quotient, 32'hFFFF_FFF2);
      chk("s100_m7_r", dif.remainder, 32'd2);

      do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, lat, bcnt);
      chk("ubig_q", dif.quotient, 32'd1);
      chk("ubig_r", dif.remainder, 32'h7FFF_FFFE);

      do_div(1'b0, 32'h0000_1234, 32'd0, lat, bcnt);
      chk("dz_lat", lat, 32'd2);
      chk("dz_q",   dif.quotient, 32'hFFFF_FFFF);
      chk("dz_r",   dif.remainder, 32'h0000_1234);
      chk("dz_flag", 32'(dif.div_zero), 32'd1);

      do_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
      chk("sdz_r",  dif.remainder, 32'hFFFF_FFFB);

      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("ovf_q",  dif.quotient, 32'h8000_0000);
      chk("ovf_r",  dif.remainder, 32'd0);
      chk("ovf_dz", 32'(dif.div_zero), 32'd0);

      // Flush 10 cycles into 10/3, then immediately divide 9/3.
      @(negedge clk);
      dif.start     = 1'b1;
      dif.is_signed = 1'b0;
      dif.dividend  = 32'd10;
      dif.divisor   = 32'd3;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (9) @(negedge clk);
      dif.flush = 1'b1;
      @(negedge clk);
      dif.flush = 1'b0;
      chk("fl_busy", 32'(dif.busy), 32'd0);
      chk("fl_done", 32'(dif.done), 32'd0);
      chk("fl_q",    dif.quotient, 32'h8000_0000);
      chk("fl_r",    dif.remainder, 32'd0);
      do_div(1'b0, 32'd9, 32'd3, lat, bcnt);
      chk("fl9_3_lat", lat, 32'd35);
      chk("fl9_3_q",   dif.quotient, 32'd3);
      chk("fl9_3_r",   dif.remainder, 32'd0);

      // A second start while busy must be ignored.
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 32'd20;
      dif.divisor  = 32'd6;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (5) @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 32'd50;
      dif.divisor  = 32'd5;
      @(negedge clk);
      dif.start = 1'b0;
      lat = 0;
      while (!dif.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("bz_lat", lat, 32'd29);
      chk("bz_q",   dif.quotient, 32'd3);
      chk("bz_r",   dif.remainder, 32'd2);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.done) nd++;
      end
      chk("bz_no2nd", nd, 32'd0);

      // Reset mid-operation clears everything immediately.
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 32'd100;
      dif.divisor  = 32'd7;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", 32'(dif.busy), 32'd0);
      chk("mr_q",    dif.quotient, 32'd0);
      chk("mr_r",    dif.remainder, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mr_idle", 32'(dif.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle 32-bit integer divider for the execute stage, signed and unsigned.
- Sits beside the single-cycle ALU. Accepts operands from the decode/execute register and returns quotient and remainder to writeback.
- Uses one instance of the existing 32-bit adder in subtract mode (Cin=1, B inverted). Runs radix-2 restoring division, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported, because the adder instance is fixed at 32 bits.
- ITER, 32, number of CALC iterations. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse. Sampled only when busy=0.
- is_signed  in  1  1 = signed division, 0 = unsigned. Captured with start.
- dividend  in  32  captured with start
- divisor  in  32  captured with start
- flush  in  1  synchronous abort from pipeline flush. Returns the block to IDLE.
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse: results are valid
- quotient  out  32  registered. Held until the next accepted start.
- remainder  out  32  registered. Held until the next accepted start.
- div_zero  out  1  divisor was 0. Valid with done, held with the results.

Behaviour:
- Reset is asynchronous, active-low, and fixed as such. On reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when start=1, capture the operands and is_signed, then go to PREP.
- PREP:
  - Take absolute values when is_signed=1.
  - Record q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend).
  - Load Q = |dividend|, R = 0, counter = 0.
  - If divisor==0, go to DONE with quotient=32'hFFFF_FFFF, remainder=dividend (the original value), div_zero=1.
  - Otherwise go to CALC.
- CALC (32 cycles). Each cycle:
  - Form S = {R[30:0], Q[31]} and keep sh = R[31].
  - Compute the trial T = S - |divisor| using the adder instance.
  - Accept when sh | carry. The adder's carry=1 means no borrow.
  - If accepted: R = T and Q = {Q[30:0],1}. Otherwise R = S and Q = {Q[30:0],0}.
  - Increment the counter. After the 32nd iteration go to FIX.
- FIX:
  - quotient = q_neg ? -Q : Q. remainder = r_neg ? -R : R.
  - Negation uses two's complement and may reuse the adder with A=0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. The results stay stable afterwards.
- Latency: start sampled at edge k → done high in the cycle after edge k+35 (PREP + 32 CALC + FIX + DONE). The divide-by-zero path has done high after edge k+2.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives quotient=0x8000_0000, remainder=0, with no special flag. The normal path produces this naturally; verify it.
- busy is 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
- start is ignored while busy=1. start during DONE is ignored; it is accepted again in IDLE.
- flush:
  - In any state, flush forces IDLE on the next edge. done is not asserted, and the results keep their previous values.
  - flush has priority over start in the same cycle.
- Reset mid-operation aborts immediately and returns all outputs to their reset values.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [2:0] div_state_t {IDLE, PREP, CALC, FIX, DONE}
  - localparam DIV_ITER = 32
  - localparam DIV_ZERO_Q = 32'hFFFF_FFFF
- Sub-module: the existing adder, instantiated once for the trial subtraction.

Test Plan:
- Unsigned 100/7 → quotient=14, remainder=2, done exactly 35 cycles after start, busy high for 34 cycles.
- Signed -100/7 → quotient=0xFFFF_FFF2 (-14), remainder=0xFFFF_FFFE (-2). Signed 100/-7 → quotient=-14, remainder=2.
- Unsigned 0xFFFF_FFFF/0x8000_0001 → quotient=1, remainder=0x7FFF_FFFE. Exercises the sh=1 accept path.
- Divide by zero, dividend=0x1234 → done 2 cycles after start, quotient=0xFFFF_FFFF, remainder=0x1234, div_zero=1.
- Signed 0x8000_0000/0xFFFF_FFFF → quotient=0x8000_0000, remainder=0.
- Start 10/3, assert flush after 10 cycles → no done pulse, busy=0 next cycle, results unchanged. An immediate new start 9/3 → quotient=3, remainder=0. A start pulse while busy produces no second done.
